// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester IDs and requester count.
// Requester IDs double as bit positions in the request and grant vectors.
package mem_arb_pkg;

    localparam int MEM_ARB_NREQ = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_IF    = 2'd0,
        REQ_LSU_R = 2'd1,
        REQ_LSU_W = 2'd2
    } arb_req_e;

    function automatic arb_req_e gnt_to_id(input logic [MEM_ARB_NREQ-1:0] gnt);
        if (gnt[REQ_LSU_W]) begin
            return REQ_LSU_W;
        end
        if (gnt[REQ_LSU_R]) begin
            return REQ_LSU_R;
        end
        return REQ_IF;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker: turns the request vector into a one-hot grant, zero latency, no backpressure.
// Fixed priority LSU write > LSU read > fetch, or round-robin after the last grant with MEM_ARB_ROUND_ROBIN_EN.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [MEM_ARB_NREQ-1:0] i_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_req_e                i_last,
`endif
    output logic [MEM_ARB_NREQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Search starts at the requester after the one granted last, wrapping fetch -> LSU read -> LSU write.
        case (i_last)
            REQ_IF: begin
                if (i_req[REQ_LSU_R])      o_gnt = 3'b010;
                else if (i_req[REQ_LSU_W]) o_gnt = 3'b100;
                else if (i_req[REQ_IF])    o_gnt = 3'b001;
            end
            REQ_LSU_R: begin
                if (i_req[REQ_LSU_W])      o_gnt = 3'b100;
                else if (i_req[REQ_IF])    o_gnt = 3'b001;
                else if (i_req[REQ_LSU_R]) o_gnt = 3'b010;
            end
            default: begin
                if (i_req[REQ_IF])         o_gnt = 3'b001;
                else if (i_req[REQ_LSU_R]) o_gnt = 3'b010;
                else if (i_req[REQ_LSU_W]) o_gnt = 3'b100;
            end
        endcase
`else
        if (i_req[REQ_LSU_W])      o_gnt = 3'b100;
        else if (i_req[REQ_LSU_R]) o_gnt = 3'b010;
        else if (i_req[REQ_IF])    o_gnt = 3'b001;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among fetch read, LSU read and LSU write; 3 cycles request-to-ack at zero wait.
// Level requests stall until acked; watchdog aborts after TIMEOUT cycles; MEM_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_if_read,
    input  logic [AW-1:0]   i_if_addr,
    output logic [DW-1:0]   o_if_data,
    output logic            o_if_ack,
    input  logic            i_lsu_read,
    input  logic [AW-1:0]   i_r_lsu_addr,
    output logic [DW-1:0]   o_r_lsu_data,
    output logic            o_lsu_r_ack,
    input  logic            i_lsu_write,
    input  logic [AW-1:0]   i_w_lsu_addr,
    input  logic [DW/8-1:0] i_w_lsu_byte_en,
    input  logic [DW-1:0]   i_w_lsu_data,
    output logic            o_lsu_w_ack,
    output logic            o_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW/8-1:0] o_mem_byte_en,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_ack
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e              r_state;
    arb_state_e              w_next;
    logic [MEM_ARB_NREQ-1:0] w_req;
    logic [MEM_ARB_NREQ-1:0] w_gnt;
    logic [MEM_ARB_NREQ-1:0] r_sel;
    logic [AW-1:0]           r_addr;
    logic [BW-1:0]           r_be;
    logic [DW-1:0]           r_wdata;
    logic                    r_we;
    logic [CW-1:0]           r_cnt;
    logic                    w_start;
    logic                    w_done;
    logic                    w_expire;
    logic                    r_if_ack;
    logic                    r_lsu_r_ack;
    logic                    r_lsu_w_ack;
    logic                    r_err;
    logic [DW-1:0]           r_if_data;
    logic [DW-1:0]           r_lsu_data;

    assign w_req = {i_lsu_write, i_lsu_read, i_if_read};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_req_e r_last;

    // Resetting to LSU write makes fetch the first candidate after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= REQ_LSU_W;
        end else if (i_clk_en && w_start) begin
            r_last <= gnt_to_id(w_gnt);
        end
    end

    mem_arb_pick u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );
`else
    mem_arb_pick u_pick (
        .i_req  (w_req),
        .o_gnt  (w_gnt)
    );
`endif

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else if (i_clk_en) begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next = GRANT;
            GRANT:   if (w_done || w_expire) w_next = RELEASE;
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs and transaction events; an ack in the expiry cycle wins over the abort.
    always_comb begin
        w_start   = (r_state == IDLE) && (|w_req);
        w_done    = (r_state == GRANT) && i_mem_ack;
        w_expire  = (r_state == GRANT) && !i_mem_ack && (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        o_mem_req = (r_state == GRANT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (i_clk_en && w_start) begin
            r_sel <= w_gnt;
            r_we  <= w_gnt[REQ_LSU_W];
            if (w_gnt[REQ_LSU_W]) begin
                r_addr  <= i_w_lsu_addr;
                r_be    <= i_w_lsu_byte_en;
                r_wdata <= i_w_lsu_data;
            end else begin
                r_addr  <= w_gnt[REQ_LSU_R] ? i_r_lsu_addr : i_if_addr;
                r_be    <= '1;
                r_wdata <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clk_en) begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (r_state == GRANT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Acks live for exactly one enabled cycle; read data is held until the next read by the same requester.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_ack    <= 1'b0;
            r_lsu_r_ack <= 1'b0;
            r_lsu_w_ack <= 1'b0;
            r_err       <= 1'b0;
            r_if_data   <= '0;
            r_lsu_data  <= '0;
        end else if (i_clk_en) begin
            r_if_ack    <= 1'b0;
            r_lsu_r_ack <= 1'b0;
            r_lsu_w_ack <= 1'b0;
            r_err       <= 1'b0;
            if (w_done || w_expire) begin
                r_if_ack    <= r_sel[REQ_IF];
                r_lsu_r_ack <= r_sel[REQ_LSU_R];
                r_lsu_w_ack <= r_sel[REQ_LSU_W];
                r_err       <= w_expire;
                if (r_sel[REQ_IF]) begin
                    r_if_data <= w_expire ? '0 : i_mem_rdata;
                end
                if (r_sel[REQ_LSU_R]) begin
                    r_lsu_data <= w_expire ? '0 : i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_we      = r_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_byte_en = r_be;
    assign o_mem_wdata   = r_wdata;
    assign o_if_ack      = r_if_ack;
    assign o_lsu_r_ack   = r_lsu_r_ack;
    assign o_lsu_w_ack   = r_lsu_w_ack;
    assign o_err         = r_err;
    assign o_if_data     = r_if_data;
    assign o_r_lsu_data  = r_lsu_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a grant/ack scoreboard checked by an independent monitor.
module tb_mem_port_arbiter;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } ack_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        if_read = 1'b0;
    logic [31:0] if_addr = '0;
    logic        lsu_read = 1'b0;
    logic [31:0] r_addr = '0;
    logic        lsu_write = 1'b0;
    logic [31:0] w_addr = '0;
    logic [3:0]  w_be = '0;
    logic [31:0] w_data = '0;
    logic [31:0] if_data_o, lsu_data_o, mem_addr_o, mem_wdata_o;
    logic        if_ack_o, lsu_r_ack_o, lsu_w_ack_o, err_o, mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;

    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [31:0] resp_data = '0;
    int          resp_delay = 0;
    bit          resp_on = 1'b0;
    int          wcnt = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = man_ack ? man_rdata : resp_rdata;

    ack_t exp_ack[$];
    gnt_t exp_gnt[$];
    int   total = 0;
    int   bad = 0;
    logic last_en = 1'b1;
    logic prev_req = 1'b0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clk_en        (clk_en),
        .i_if_read       (if_read),
        .i_if_addr       (if_addr),
        .o_if_data       (if_data_o),
        .o_if_ack        (if_ack_o),
        .i_lsu_read      (lsu_read),
        .i_r_lsu_addr    (r_addr),
        .o_r_lsu_data    (lsu_data_o),
        .o_lsu_r_ack     (lsu_r_ack_o),
        .i_lsu_write     (lsu_write),
        .i_w_lsu_addr    (w_addr),
        .i_w_lsu_byte_en (w_be),
        .i_w_lsu_data    (w_data),
        .o_lsu_w_ack     (lsu_w_ack_o),
        .o_err           (err_o),
        .o_mem_req       (mem_req_o),
        .o_mem_we        (mem_we_o),
        .o_mem_addr      (mem_addr_o),
        .o_mem_byte_en   (mem_be_o),
        .o_mem_wdata     (mem_wdata_o),
        .i_mem_rdata     (mem_rdata),
        .i_mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) last_en <= clk_en;

    // Memory model: acks resp_delay cycles into a grant, holds the pulse for one cycle.
    always @(negedge clk) begin
        if (rst) begin
            resp_ack = 1'b0;
            wcnt = 0;
        end else if (resp_ack) begin
            resp_ack = 1'b0;
            wcnt = 0;
        end else if (mem_req_o && resp_on) begin
            if (wcnt >= resp_delay) begin
                resp_ack = 1'b1;
                resp_rdata = resp_data;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: checks each new grant and each ack against the scoreboard queues.
    always @(negedge clk) begin : mon
        int          nack;
        int          id;
        logic [31:0] d;
        ack_t        a;
        gnt_t        g;
        if (rst) begin
            prev_req = 1'b0;
        end else if (last_en) begin
            if (mem_req_o && !prev_req) begin
                total++;
                if (exp_gnt.size() == 0) begin
                    bad++;
                    $display("FAIL grant_unexpected: addr=%h we=%b, none expected", mem_addr_o, mem_we_o);
                end else begin
                    g = exp_gnt.pop_front();
                    if (mem_we_o !== g.we || mem_addr_o !== g.addr || mem_be_o !== g.be ||
                        (g.we && mem_wdata_o !== g.wdata)) begin
                        bad++;
                        $display("FAIL grant_fields: got we=%b addr=%h be=%h wdata=%h want we=%b addr=%h be=%h wdata=%h",
                                 mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, g.we, g.addr, g.be, g.wdata);
                    end
                end
            end
            prev_req = mem_req_o;
            nack = int'(if_ack_o) + int'(lsu_r_ack_o) + int'(lsu_w_ack_o);
            if (nack > 1) begin
                total++;
                bad++;
                $display("FAIL ack_onehot: %0d acks high together, want at most 1", nack);
            end else if (nack == 1) begin
                id = if_ack_o ? 0 : (lsu_r_ack_o ? 1 : 2);
                d  = (id == 0) ? if_data_o : lsu_data_o;
                total++;
                if (exp_ack.size() == 0) begin
                    bad++;
                    $display("FAIL ack_unexpected: requester %0d acked, none expected", id);
                end else begin
                    a = exp_ack.pop_front();
                    if (id != a.id || err_o !== a.err || (id != 2 && d !== a.data)) begin
                        bad++;
                        $display("FAIL ack_fields: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                                 id, err_o, d, a.id, a.err, a.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Waits for any ack; n = negedges waited, reqc = negedges with o_mem_req high.
    task automatic wait_ack(input int max, input bit drop, output int n, output int reqc);
        n = 0;
        reqc = 0;
        forever begin
            @(negedge clk);
            n++;
            if (mem_req_o) reqc++;
            if (if_ack_o || lsu_r_ack_o || lsu_w_ack_o) begin
                if (drop) begin
                    if (if_ack_o)    if_read = 1'b0;
                    if (lsu_r_ack_o) lsu_read = 1'b0;
                    if (lsu_w_ack_o) lsu_write = 1'b0;
                end
                return;
            end
            if (n >= max) begin
                total++;
                bad++;
                $display("FAIL ack_timeout: no ack within %0d cycles", max);
                return;
            end
        end
    endtask

    task automatic wait_req(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (mem_req_o) return;
        end
        total++;
        bad++;
        $display("FAIL req_timeout: o_mem_req not seen within %0d cycles", max);
    endtask

    initial begin
        int n;
        int rc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {27'd0, mem_req_o, mem_we_o, if_ack_o, lsu_r_ack_o, lsu_w_ack_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_be_wdata", mem_wdata_o | {28'd0, mem_be_o}, 32'd0);
        chk("rst_data", if_data_o | lsu_data_o, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single fetch read, memory acks after 2 wait cycles
        resp_on = 1'b1; resp_delay = 2; resp_data = 32'hDEADBEEF;
        exp_gnt.push_back(gnt_t'{1'b0, 32'h100, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{0, 32'hDEADBEEF, 1'b0});
        @(posedge clk); #1 if_addr = 32'h100; if_read = 1'b1;
        wait_ack(40, 1'b1, n, rc);
        chk("fetch_latency", n, 5);
        chk("fetch_req_cycles", rc, 3);

        // Write and read raised together: write first, read after RELEASE
        resp_delay = 0; resp_data = 32'hCAFEF00D;
        exp_gnt.push_back(gnt_t'{1'b1, 32'h200, 4'h3, 32'h12345678});
        exp_gnt.push_back(gnt_t'{1'b0, 32'h240, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{2, 32'h0, 1'b0});
        exp_ack.push_back(ack_t'{1, 32'hCAFEF00D, 1'b0});
        @(posedge clk); #1
        w_addr = 32'h200; w_be = 4'h3; w_data = 32'h12345678; lsu_write = 1'b1;
        r_addr = 32'h240; lsu_read = 1'b1;
        wait_ack(40, 1'b1, n, rc);
        chk("zero_wait_latency", n, 3);
        wait_ack(40, 1'b1, n, rc);
        chk("read_after_release", n, 3);

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Round-robin from reset with all three requesting continuously
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        resp_delay = 0; resp_data = 32'h11112222;
        exp_gnt.push_back(gnt_t'{1'b0, 32'h400, 4'hF, 32'h0});
        exp_gnt.push_back(gnt_t'{1'b0, 32'h440, 4'hF, 32'h0});
        exp_gnt.push_back(gnt_t'{1'b1, 32'h480, 4'hC, 32'hA5A5A5A5});
        exp_gnt.push_back(gnt_t'{1'b0, 32'h400, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{0, 32'h11112222, 1'b0});
        exp_ack.push_back(ack_t'{1, 32'h11112222, 1'b0});
        exp_ack.push_back(ack_t'{2, 32'h0, 1'b0});
        exp_ack.push_back(ack_t'{0, 32'h11112222, 1'b0});
        @(posedge clk); #1
        if_addr = 32'h400; if_read = 1'b1;
        r_addr = 32'h440; lsu_read = 1'b1;
        w_addr = 32'h480; w_be = 4'hC; w_data = 32'hA5A5A5A5; lsu_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(40, 1'b0, n, rc);
            chk("rr_spacing", n, 3);
        end
        if_read = 1'b0; lsu_read = 1'b0; lsu_write = 1'b0;
`else
        // Fixed priority: LSU read beats fetch
        resp_delay = 1; resp_data = 32'h0BADCAFE;
        exp_gnt.push_back(gnt_t'{1'b0, 32'h340, 4'hF, 32'h0});
        exp_gnt.push_back(gnt_t'{1'b0, 32'h380, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{1, 32'h0BADCAFE, 1'b0});
        exp_ack.push_back(ack_t'{0, 32'h13579BDF, 1'b0});
        @(posedge clk); #1
        r_addr = 32'h340; lsu_read = 1'b1;
        if_addr = 32'h380; if_read = 1'b1;
        wait_ack(40, 1'b1, n, rc);
        chk("prio_first_latency", n, 4);
        resp_data = 32'h13579BDF;
        wait_ack(40, 1'b1, n, rc);
        chk("prio_second_latency", n, 4);
`endif

        // Watchdog abort of an LSU read, then a stray late ack
        resp_on = 1'b0;
        exp_gnt.push_back(gnt_t'{1'b0, 32'h500, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{1, 32'h0, 1'b1});
        @(posedge clk); #1 r_addr = 32'h500; lsu_read = 1'b1;
        wait_ack(40, 1'b1, n, rc);
        chk("timeout_latency", n, 10);
        chk("timeout_req_cycles", rc, 8);
        man_rdata = 32'hFFFFFFFF; man_ack = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 man_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ack_ignored", {28'd0, mem_req_o, if_ack_o, lsu_r_ack_o, lsu_w_ack_o}, 32'd0);
        end

        // Asynchronous reset in the middle of a write grant
        exp_gnt.push_back(gnt_t'{1'b1, 32'h600, 4'h9, 32'hFEEDFACE});
        @(posedge clk); #1
        w_addr = 32'h600; w_be = 4'h9; w_data = 32'hFEEDFACE; lsu_write = 1'b1;
        wait_req(20);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_flags", {27'd0, mem_we_o, if_ack_o, lsu_r_ack_o, lsu_w_ack_o, err_o}, 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        chk("arst_wdata_be", mem_wdata_o | {28'd0, mem_be_o}, 32'd0);
        chk("arst_data", if_data_o | lsu_data_o, 32'd0);
        @(negedge clk);
        chk("arst_no_ack", {29'd0, if_ack_o, lsu_r_ack_o, lsu_w_ack_o}, 32'd0);
        resp_on = 1'b1; resp_delay = 1;
        exp_gnt.push_back(gnt_t'{1'b1, 32'h600, 4'h9, 32'hFEEDFACE});
        exp_ack.push_back(ack_t'{2, 32'h0, 1'b0});
        #2 rst = 1'b0;
        wait_ack(40, 1'b1, n, rc);
        chk("regrant_after_rst", n, 3);

        // Clock enable low during GRANT with the memory ack present
        resp_on = 1'b0;
        exp_gnt.push_back(gnt_t'{1'b0, 32'h300, 4'hF, 32'h0});
        exp_ack.push_back(ack_t'{0, 32'h5A5AA5A5, 1'b0});
        @(posedge clk); #1 if_addr = 32'h300; if_read = 1'b1;
        wait_req(20);
        @(posedge clk); #1 clk_en = 1'b0; man_rdata = 32'h5A5AA5A5; man_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("freeze_req", {31'd0, mem_req_o}, 32'd1);
            chk("freeze_no_ack", {29'd0, if_ack_o, lsu_r_ack_o, lsu_w_ack_o}, 32'd0);
        end
        @(posedge clk); #1 clk_en = 1'b1;
        @(posedge clk); #1 man_ack = 1'b0;
        wait_ack(10, 1'b1, n, rc);
        chk("freeze_resume", n, 1);

        repeat (3) @(negedge clk);
        chk("sb_acks_drained", exp_ack.size(), 0);
        chk("sb_grants_drained", exp_gnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
